// File: rtl/hp_damage_arbiter.sv
// rtl/hp_damage_arbiter.sv - shared-window damage arbiter: round-robin hit grant, saturating HP, invulnerability timer
module hp_damage_arbiter #(
   parameter int N_SRC         = 4,
   parameter int HP_MAX        = 100,
   parameter int DAMAGE        = 10,
   parameter int INVULN_CYCLES = 32500000
) (
   input  logic             pclk,
   input  logic             rst,
   input  logic             enable_in,
   input  logic             restart_in,
   input  logic [N_SRC-1:0] damage_in,
   output logic [7:0]       hp_out,
   output logic             hit_out,
   output logic [2:0]       hit_src_out,
   output logic             invuln_out,
   output logic             game_over_out
);

   typedef enum logic [1:0] {IDLE, INVULN, DEAD} state_t;

   localparam logic [7:0]  HP_INIT  = 8'(HP_MAX);
   localparam logic [7:0]  DMG      = 8'(DAMAGE);
   localparam logic [27:0] CNT_LAST = 28'(INVULN_CYCLES - 1);

   state_t             state;
   logic [N_SRC-1:0]   pending;
   logic [2:0]         rr_ptr;
   logic [27:0]        counter;

   logic [N_SRC-1:0]   req;
   logic [N_SRC-1:0]   req_rot;
   logic               grant_valid;
   logic [3:0]         grant_sum;
   logic [2:0]         grant_idx;
   logic [2:0]         next_ptr;
   logic [7:0]         new_hp;

   // Rotate requests so bit 0 is the current round-robin head, then take the first set bit.
   always_comb begin
      req         = pending | damage_in;
      req_rot     = N_SRC'({req, req} >> rr_ptr);
      grant_valid = 1'b0;
      grant_sum   = 4'd0;
      for (int k = 0; k < N_SRC; k++) begin
         if (!grant_valid && req_rot[k]) begin
            grant_valid = 1'b1;
            grant_sum   = {1'b0, rr_ptr} + 4'(k);
         end
      end
      grant_idx = (grant_sum >= 4'(N_SRC)) ? 3'(grant_sum - 4'(N_SRC)) : grant_sum[2:0];
      next_ptr  = (grant_idx == 3'(N_SRC - 1)) ? 3'd0 : grant_idx + 3'd1;
      new_hp    = (hp_out <= DMG) ? 8'd0 : hp_out - DMG;
   end

   always_ff @(posedge pclk) begin
      if (rst || restart_in) begin
         state         <= IDLE;
         pending       <= '0;
         rr_ptr        <= 3'd0;
         counter       <= 28'd0;
         hp_out        <= HP_INIT;
         hit_out       <= 1'b0;
         hit_src_out   <= 3'd0;
         invuln_out    <= 1'b0;
         game_over_out <= 1'b0;
      end else begin
         hit_out <= 1'b0;
         case (state)
            IDLE: begin
               if (enable_in) begin
                  if (grant_valid) begin
                     hit_out     <= 1'b1;
                     hit_src_out <= grant_idx;
                     rr_ptr      <= next_ptr;
                     pending     <= '0;
                     counter     <= 28'd0;
                     hp_out      <= new_hp;
                     if (new_hp == 8'd0) begin
                        state         <= DEAD;
                        game_over_out <= 1'b1;
                        invuln_out    <= 1'b0;
                     end else begin
                        state      <= INVULN;
                        invuln_out <= 1'b1;
                     end
                  end
               end else begin
                  pending <= pending | damage_in;
               end
            end
            INVULN: begin
               if (enable_in) begin
                  if (counter == CNT_LAST) begin
                     counter    <= 28'd0;
                     invuln_out <= 1'b0;
                     state      <= IDLE;
                  end else begin
                     counter <= counter + 28'd1;
                  end
               end
            end
            DEAD: begin
               game_over_out <= 1'b1;
               hp_out        <= 8'd0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hp_damage_arbiter.sv
// tb/tb_hp_damage_arbiter.sv - directed self-checking bench for hp_damage_arbiter
module tb_hp_damage_arbiter;

   logic       pclk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b1;
   logic       restart = 1'b0;
   logic [3:0] damage = 4'd0;
   logic [3:0] damage2 = 4'd0;

   logic [7:0] hp, hp2;
   logic       hit, hit2, inv, inv2, go, go2;
   logic [2:0] src, src2;

   int checks = 0;
   int errors = 0;

   hp_damage_arbiter #(.N_SRC(4), .HP_MAX(100), .DAMAGE(10), .INVULN_CYCLES(8)) dut (
      .pclk(pclk), .rst(rst), .enable_in(enable), .restart_in(restart), .damage_in(damage),
      .hp_out(hp), .hit_out(hit), .hit_src_out(src), .invuln_out(inv), .game_over_out(go));

   hp_damage_arbiter #(.N_SRC(4), .HP_MAX(100), .DAMAGE(30), .INVULN_CYCLES(8)) dut30 (
      .pclk(pclk), .rst(rst), .enable_in(enable), .restart_in(restart), .damage_in(damage2),
      .hp_out(hp2), .hit_out(hit2), .hit_src_out(src2), .invuln_out(inv2), .game_over_out(go2));

   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   task automatic do_restart();
      restart = 1'b1;
      step();
      restart = 1'b0;
   endtask

   // Grant edge already seen; invuln must stay high 7 more cycles, then drop.
   task automatic wait_window(input int exp_hp);
      repeat (7) begin
         step();
         chk("win_inv_hi", inv, 1);
         chk("win_hit_lo", hit, 0);
      end
      step();
      chk("win_inv_lo", inv, 0);
      chk("win_hp", hp, exp_hp);
   endtask

   task automatic do_hit(input logic [3:0] d, input int exp_src, input int exp_hp);
      damage = d;
      step();
      damage = 4'd0;
      chk("hit_pulse", hit, 1);
      chk("hit_src", src, exp_src);
      chk("hit_hp", hp, exp_hp);
   endtask

   initial begin
      // Reset state
      repeat (2) step();
      rst = 1'b0;
      chk("rst_hp", hp, 100);
      chk("rst_hit", hit, 0);
      chk("rst_src", src, 0);
      chk("rst_inv", inv, 0);
      chk("rst_go", go, 0);

      // Single hit, second pulse inside the window is ignored
      do_hit(4'b0010, 1, 90);
      chk("single_inv", inv, 1);
      for (int i = 1; i <= 7; i++) begin
         damage = (i == 4) ? 4'b0010 : 4'b0000;
         step();
         damage = 4'd0;
         chk("single_win_inv", inv, 1);
         chk("single_win_hit", hit, 0);
         chk("single_win_hp", hp, 90);
      end
      step();
      chk("single_end_inv", inv, 0);
      step();
      chk("single_no_late_hit", hit, 0);
      chk("single_hp_kept", hp, 90);

      // Simultaneous hits, round-robin, held requests ignored in window
      do_restart();
      for (int r = 0; r < 3; r++) begin
         do_hit(4'b1111, r, 90 - 10 * r);
         repeat (8) begin
            step();
            chk("simul_no_hit", hit, 0);
            chk("simul_hp", hp, 90 - 10 * r);
         end
         damage = 4'd0;
         chk("simul_inv_end", inv, 0);
      end

      // Restart with simultaneous damage while invulnerable at hp 80
      do_restart();
      do_hit(4'b0001, 0, 90);
      wait_window(90);
      do_hit(4'b0001, 0, 80);
      chk("rs_pre_inv", inv, 1);
      restart = 1'b1;
      damage = 4'b1111;
      step();
      restart = 1'b0;
      damage = 4'd0;
      chk("rs_hp", hp, 100);
      chk("rs_inv", inv, 0);
      chk("rs_hit", hit, 0);
      chk("rs_go", go, 0);
      step();
      chk("rs_dropped_hit", hit, 0);
      chk("rs_dropped_hp", hp, 100);

      // Pause: request held, granted one cycle after enable returns
      enable = 1'b0;
      damage = 4'b0100;
      step();
      damage = 4'd0;
      repeat (5) begin
         step();
         chk("pause_no_hit", hit, 0);
         chk("pause_hp", hp, 100);
      end
      enable = 1'b1;
      step();
      chk("pause_hit", hit, 1);
      chk("pause_src", src, 2);
      chk("pause_hp_after", hp, 90);
      chk("pause_inv", inv, 1);

      // Pause mid-window stretches invuln by the paused cycles
      repeat (3) begin
         step();
         chk("pmid_inv_a", inv, 1);
      end
      enable = 1'b0;
      repeat (4) begin
         step();
         chk("pmid_inv_paused", inv, 1);
      end
      enable = 1'b1;
      repeat (4) begin
         step();
         chk("pmid_inv_b", inv, 1);
      end
      step();
      chk("pmid_inv_end", inv, 0);

      // Saturation and death on both instances (DAMAGE 10 and 30)
      do_restart();
      for (int k = 1; k <= 10; k++) begin
         int e2;
         e2 = 100 - 30 * k;
         if (e2 < 0) e2 = 0;
         damage2 = 4'b0001;
         do_hit(4'b0001, 0, 100 - 10 * k);
         damage2 = 4'd0;
         chk("sat30_hit", hit2, (k <= 4) ? 1 : 0);
         chk("sat30_hp", hp2, e2);
         if (k == 4) begin
            chk("sat30_go", go2, 1);
            chk("sat30_inv", inv2, 0);
         end
         if (k < 10) begin
            repeat (8) step();
            chk("sat_inv_end", inv, 0);
            chk("sat_go_lo", go, 0);
         end
      end
      chk("dead_go", go, 1);
      chk("dead_inv", inv, 0);
      damage = 4'b1111;
      step();
      damage = 4'd0;
      chk("dead_no_hit", hit, 0);
      chk("dead_hp", hp, 0);
      step();
      chk("dead_go_hold", go, 1);
      chk("dead_no_hit2", hit, 0);

      // Reset while dead
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rdead_hp", hp, 100);
      chk("rdead_inv", inv, 0);
      chk("rdead_hit", hit, 0);
      chk("rdead_go", go, 0);
      chk("rdead_src", src, 0);
      chk("rdead30_hp", hp2, 100);
      chk("rdead30_go", go2, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
